// File: rtl/pe_sequencer.sv
// pe_sequencer: loads instructions and data into a PE, runs the iterations, then waits for the PE result.
module pe_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int REG_NUM    = 16,
    parameter int IMEM_DEPTH = 64,
    parameter int ITER_WIDTH = 8,
    parameter int DRAIN_MAX  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(IMEM_DEPTH):0]   inst_cnt,
    input  logic [ITER_WIDTH-1:0]         iter_cnt,
    input  logic [ITER_WIDTH-1:0]         iter_len,
    input  logic                          host_inst_valid,
    input  logic [INST_WIDTH-1:0]         host_inst,
    output logic                          host_inst_ready,
    input  logic                          host_data_valid,
    input  logic [2*DATA_WIDTH-1:0]       host_data,
    output logic                          host_data_ready,
    output logic                          pe_inst_in_v,
    output logic [INST_WIDTH-1:0]         pe_inst_in,
    output logic                          pe_din_v,
    output logic [2*DATA_WIDTH-1:0]       pe_din,
    output logic                          pe_alpha_v,
    input  logic                          pe_dout_v,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout
);
    localparam int IW  = $clog2(IMEM_DEPTH) + 1;
    localparam int DCW = $clog2(2 * REG_NUM + 1);
    localparam int TW  = $clog2(DRAIN_MAX + 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(2 * REG_NUM - 1);
    localparam logic [TW-1:0]  T_LAST = TW'(DRAIN_MAX - 1);
    typedef enum logic [2:0] {IDLE, LD_INST, LD_DATA, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] inst_q, icnt;
    logic [ITER_WIDTH-1:0] iter_q, len_q, cyc, it, it_n;
    logic [DCW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic inst_hs, data_hs, cyc_end, run_end, drain_to;
    assign inst_hs  = host_inst_valid && host_inst_ready;
    assign data_hs  = host_data_valid && host_data_ready;
    assign cyc_end  = cyc == len_q - 1'b1;
    assign run_end  = cyc_end && it == iter_q - 1'b1;
    assign drain_to = tcnt == T_LAST;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && iter_cnt != '0) state_n = inst_cnt != '0 ? LD_INST : LD_DATA;
            LD_INST: if (inst_hs && icnt == inst_q - 1'b1) state_n = LD_DATA;
            LD_DATA: if (data_hs && dcnt == D_LAST) state_n = RUN;
            RUN:     if (run_end) state_n = DRAIN;
            DRAIN:   if (pe_dout_v || drain_to) state_n = DONE;
            default: state_n = IDLE;
        endcase
        it_n = state_n != RUN ? '0 : (state == RUN && cyc_end) ? it + 1'b1 : it;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            host_inst_ready <= 1'b0;
            host_data_ready <= 1'b0;
            pe_inst_in_v    <= 1'b0;
            pe_din_v        <= 1'b0;
            pe_alpha_v      <= 1'b0;
            pe_inst_in      <= '0;
            pe_din          <= '0;
            inst_q          <= '0;
            iter_q          <= '0;
            len_q           <= '0;
            icnt            <= '0;
            dcnt            <= '0;
            cyc             <= '0;
            it              <= '0;
            tcnt            <= '0;
        end else begin
            state           <= state_n;
            busy            <= state_n != IDLE;
            done            <= state_n == DONE;
            host_inst_ready <= state_n == LD_INST;
            host_data_ready <= state_n == LD_DATA;
            pe_inst_in_v    <= inst_hs;
            pe_din_v        <= data_hs;
            pe_alpha_v      <= state_n == RUN && it_n == iter_q - 1'b1;
            if (inst_hs) pe_inst_in <= host_inst;
            if (data_hs) pe_din <= host_data;
            icnt <= state_n != LD_INST ? '0 : icnt + IW'(inst_hs);
            dcnt <= state_n != LD_DATA ? '0 : dcnt + DCW'(data_hs);
            cyc  <= (state == RUN && !cyc_end) ? cyc + 1'b1 : '0;
            it   <= it_n;
            tcnt <= state == DRAIN ? tcnt + 1'b1 : '0;
            // a zero iteration length still runs one cycle per iteration
            if (state == IDLE && state_n != IDLE) begin
                inst_q  <= inst_cnt;
                iter_q  <= iter_cnt;
                len_q   <= iter_len == '0 ? ITER_WIDTH'(1) : iter_len;
                timeout <= 1'b0;
            end else if (state == DRAIN && !pe_dout_v && drain_to) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: randomized jobs checked against stream-level expectations of the sequencer.
module tb_pe_sequencer;
    logic clk = 1'b0;
    logic rst, start, host_inst_valid, host_data_valid, pe_dout_v;
    logic [6:0] inst_cnt;
    logic [7:0] iter_cnt, iter_len;
    logic [31:0] host_inst, host_data, pe_inst_in, pe_din;
    logic host_inst_ready, host_data_ready, pe_inst_in_v, pe_din_v, pe_alpha_v, busy, done, timeout;
    int n_vec = 0;
    int n_bad = 0;
    bit prev_to = 1'b0;
    always #5 clk = ~clk;
    pe_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .inst_cnt(inst_cnt), .iter_cnt(iter_cnt),
        .iter_len(iter_len), .host_inst_valid(host_inst_valid), .host_inst(host_inst),
        .host_inst_ready(host_inst_ready), .host_data_valid(host_data_valid),
        .host_data(host_data), .host_data_ready(host_data_ready), .pe_inst_in_v(pe_inst_in_v),
        .pe_inst_in(pe_inst_in), .pe_din_v(pe_din_v), .pe_din(pe_din), .pe_alpha_v(pe_alpha_v),
        .pe_dout_v(pe_dout_v), .busy(busy), .done(done), .timeout(timeout)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    // dly: cycles after RUN ends that pe_dout_v pulses; outside 1..31 the drain must time out
    task automatic run_job(input int ni, input int nt, input int nl, input int vm, input int dly);
        logic [31:0] iw[$], dw[$];
        int ii = 0, di = 0, cyc = 0, n_i = 0, n_d = 0, last_inst = -1, first_din = -1, last_din = -1;
        int a_first = -1, a_last = -1, a_cnt = 0, done_at = -1, busy_lo = 0, len;
        bit run_over = 0, ok_i = 1, ok_d = 1, hs_i, hs_d, exp_to, to_at_done = 0;
        len = nl == 0 ? 1 : nl;
        exp_to = !(dly >= 1 && dly <= 31);
        for (int k = 0; k < ni + 4; k++) iw.push_back($urandom);
        for (int k = 0; k < 36; k++) dw.push_back($urandom);
        start = 1; inst_cnt = 7'(ni); iter_cnt = 8'(nt); iter_len = 8'(nl);
        host_inst = iw[0]; host_data = dw[0];
        host_inst_valid = 1; host_data_valid = vm == 0; pe_dout_v = 0;
        while (done_at < 0 && cyc < 2000) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("timeout_held", timeout, prev_to);
            end
            if (cyc == 1) check("timeout_cleared", timeout, 0);
            if (cyc >= 1 && !busy) busy_lo++;
            hs_i = host_inst_valid && host_inst_ready;
            hs_d = host_data_valid && host_data_ready;
            if (pe_inst_in_v) begin
                ok_i &= pe_inst_in === iw[n_i];
                n_i++; last_inst = cyc;
            end
            if (pe_din_v) begin
                ok_d &= pe_din === dw[n_d];
                if (first_din < 0) first_din = cyc;
                n_d++; last_din = cyc;
            end
            if (pe_alpha_v) begin
                if (a_first < 0) a_first = cyc;
                a_last = cyc; a_cnt++;
            end else if (a_cnt > 0) run_over = 1;
            if (done) begin done_at = cyc; to_at_done = timeout; end
            @(posedge clk); #1;
            cyc++;
            if (hs_i) ii++;
            if (hs_d) di++;
            start = done_at < 0 && $urandom_range(0, 3) == 0;
            inst_cnt = 7'($urandom); iter_cnt = 8'($urandom); iter_len = 8'($urandom);
            host_inst = iw[ii]; host_data = dw[di];
            host_inst_valid = vm == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
            host_data_valid = vm == 0 ? 1'b1 : vm == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            pe_dout_v = cyc == 2 || (dly > 0 && run_over && cyc == a_last + 1 + dly);
        end
        start = 0; pe_dout_v = 0; host_inst_valid = 0; host_data_valid = 0;
        check("done_seen", done_at >= 0, 1);
        check("inst_count", n_i, ni);
        check("inst_words", ok_i, 1);
        check("din_count", n_d, 32);
        check("din_words", ok_d, 1);
        if (ni > 0) check("inst_before_data", first_din > last_inst, 1);
        check("alpha_len", a_cnt, len);
        check("alpha_contig", a_last - a_first + 1, a_cnt);
        check("alpha_start", a_first, last_din + (nt - 1) * len);
        check("done_time", done_at, exp_to ? a_last + 33 : a_last + 2 + dly);
        check("timeout", to_at_done, exp_to);
        check("busy_held", busy_lo, 0);
        prev_to = to_at_done;
    endtask
    task automatic reset_mid();
        int n_d = 0, cyc = 0;
        start = 1; inst_cnt = 7'd2; iter_cnt = 8'd1; iter_len = 8'd2;
        host_inst_valid = 1; host_data_valid = 1; host_inst = $urandom; host_data = $urandom;
        while (n_d < 10 && cyc < 200) begin
            @(negedge clk);
            if (pe_din_v) n_d++;
            @(posedge clk); #1;
            cyc++; start = 0; host_inst = $urandom; host_data = $urandom;
        end
        check("rst_words_seen", n_d, 10);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; host_inst_valid = 0; host_data_valid = 0;
        @(negedge clk);
        check("rst_flags", {busy, done, timeout, host_inst_ready, host_data_ready,
                            pe_inst_in_v, pe_din_v, pe_alpha_v}, 0);
        check("rst_inst", pe_inst_in, 0);
        check("rst_din", pe_din, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_idle", {busy, pe_din_v}, 0);
        @(posedge clk); #1;
        prev_to = 0;
    endtask
    initial begin
        rst = 1; start = 0; inst_cnt = 0; iter_cnt = 0; iter_len = 0;
        host_inst_valid = 0; host_inst = 0; host_data_valid = 0; host_data = 0; pe_dout_v = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {busy, done, timeout, host_inst_ready, host_data_ready,
                              pe_inst_in_v, pe_din_v, pe_alpha_v}, 0);
        check("reset_data", {pe_inst_in, pe_din}, 0);
        @(posedge clk); #1;
        rst = 0;
        run_job(3, 2, 4, 0, 5);
        run_job(3, 2, 4, 1, 5);
        run_job(0, 1, 0, 0, 3);
        run_job(2, 1, 2, 0, -1);
        run_job(1, 1, 1, 2, 1);
        start = 1; iter_cnt = 0; inst_cnt = 3; iter_len = 4;
        repeat (3) begin
            @(negedge clk);
            check("iter0_busy", busy, 0);
            check("iter0_ready", host_inst_ready | host_data_ready, 0);
            @(posedge clk); #1;
        end
        start = 0;
        reset_mid();
        run_job(4, 3, 3, 2, 7);
        run_job(127, 1, 255, 2, 31);
        run_job(1, 255, 1, 0, 32);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 20), $urandom_range(1, 6), $urandom_range(0, 8),
                    $urandom_range(0, 2), $urandom_range(0, 33) - 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
